// File: rtl/adc_spi_cfg_sequencer.sv
// SPI configuration sequencer for AD9231-family ADCs: walks a register table and writes it
// (with optional readback check) to every selected chip over a shared 3-wire bus.
module adc_spi_cfg_sequencer #(
  parameter int NUM_CS      = 2,
  parameter int NUM_REGS    = 8,
  parameter int CLK_DIV     = 4,
  parameter int VERIFY      = 1,
  parameter int REPEAT_MODE = 1,
  localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk_100m,
  input  logic              reset_n,
  input  logic              start,
  input  logic              trig_1hz,
  input  logic [NUM_CS-1:0] chan_mask,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [12:0]       tbl_addr,
  input  logic [7:0]        tbl_data,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              spi_sclk,
  output logic              sdio_o,
  output logic              sdio_oe,
  input  logic              sdio_i,
  output logic              adc_pdwn,
  output logic              busy,
  output logic              done,
  output logic [NUM_CS-1:0] cfg_err
);

  localparam int CH_W = $clog2(NUM_CS + 1);
  localparam int HC_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_HOLD, S_GAP, S_DONE} state_t;

  state_t              state, state_nx;
  logic [HC_W-1:0]     hcnt;
  logic [5:0]          half;
  logic [CH_W-1:0]     ch;
  logic [CH_W-1:0]     sel_ch;
  logic                sel_found;
  logic [IDX_W-1:0]    idx;
  logic                phase;
  logic [NUM_CS-1:0]   mask_q;
  logic                auto_q;
  logic                trig_q;
  logic                trigger;
  logic                half_end;
  logic                active;
  logic [23:0]         sh_q;
  logic [7:0]          exp_q;
  logic [7:0]          rx_q;
  logic                sclk_d, oe_d, sdio_d;
  logic [NUM_CS-1:0]   cs_n_d;

  assign half_end = (hcnt == HC_W'(CLK_DIV - 1));
  assign trigger  = auto_q | start | ((REPEAT_MODE != 0) & trig_1hz & ~trig_q);
  assign tbl_idx  = idx;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign adc_pdwn = 1'b0;

  // Lowest selected chip at or above the current one; none left ends the pass.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = ch;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (mask_q[i] && (CH_W'(i) >= ch)) begin
        sel_found = 1'b1;
        sel_ch    = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (trigger) state_nx = S_LOAD;
      S_LOAD:  state_nx = sel_found ? S_SHIFT : S_DONE;
      S_SHIFT: if (half_end && half == 6'd48) state_nx = S_HOLD;
      S_HOLD:  if (half_end) state_nx = S_GAP;
      S_GAP:   if (half_end && half == 6'd1) state_nx = S_LOAD;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Half-period timing and table/chip walk.
  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      hcnt    <= '0;
      half    <= '0;
      ch      <= '0;
      idx     <= '0;
      phase   <= 1'b0;
      mask_q  <= '0;
      cfg_err <= '0;
      auto_q  <= 1'b1;
      trig_q  <= 1'b0;
    end else begin
      auto_q <= 1'b0;
      trig_q <= trig_1hz;
      if (state != state_nx) begin
        hcnt <= '0;
        half <= '0;
      end else if (half_end) begin
        hcnt <= '0;
        half <= half + 6'd1;
      end else begin
        hcnt <= hcnt + HC_W'(1);
      end
      if (state == S_IDLE && trigger) begin
        mask_q  <= chan_mask;
        ch      <= '0;
        idx     <= '0;
        phase   <= 1'b0;
        cfg_err <= '0;
      end
      if (state == S_LOAD && sel_found) ch <= sel_ch;
      if (state == S_HOLD && half_end && phase && (rx_q != exp_q)) begin
        for (int i = 0; i < NUM_CS; i++) begin
          if (CH_W'(i) == ch) cfg_err[i] <= 1'b1;
        end
      end
      if (state == S_GAP && half_end && half == 6'd1) begin
        if ((VERIFY != 0) && !phase) begin
          phase <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (idx == IDX_W'(NUM_REGS - 1)) begin
            idx <= '0;
            ch  <= ch + CH_W'(1);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
      end
    end
  end

  // Frame shifter, expected value and readback capture; contents only matter inside a frame.
  always_ff @(posedge clk_100m) begin
    if (state == S_LOAD) begin
      sh_q  <= {phase, 2'b00, tbl_addr, (phase ? 8'h00 : tbl_data)};
      exp_q <= tbl_data;
    end else if (state == S_SHIFT && half_end && half != 6'd0 && !half[0]) begin
      sh_q <= {sh_q[22:0], 1'b0};
    end
    if (state == S_SHIFT && phase && half >= 6'd34 && !half[0] && hcnt == '0)
      rx_q <= {rx_q[6:0], sdio_i};
  end

  // Halves: 0 = setup, 2k+1 = SCLK low, 2k+2 = SCLK high for bit period k.
  always_comb begin
    active = (state == S_SHIFT) || (state == S_HOLD);
    sclk_d = (state == S_SHIFT) && (half != 6'd0) && !half[0];
    oe_d   = active && !(phase && ((state == S_HOLD) || (half >= 6'd33)));
    sdio_d = oe_d && sh_q[23];
    for (int i = 0; i < NUM_CS; i++) cs_n_d[i] = !(active && (ch == CH_W'(i)));
  end

  // Pins are registered so the bus sees glitch-free edges; all relations shift by one cycle together.
  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      spi_cs_n <= '1;
      spi_sclk <= 1'b0;
      sdio_o   <= 1'b0;
      sdio_oe  <= 1'b0;
    end else begin
      spi_cs_n <= cs_n_d;
      spi_sclk <= sclk_d;
      sdio_o   <= sdio_d;
      sdio_oe  <= oe_d;
    end
  end

endmodule
